// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC result path.
// Holds the accumulator width/type, the saturation clamp used when MAC_SAT_EN
// is defined, and a power-of-two check used for elaboration-time sanity checks.
package mac_pkg;

  localparam int unsigned MAC_ACC_W = 20;

  typedef logic signed [MAC_ACC_W-1:0] mac_acc_t;

  // Clamp a signed accumulator value into the signed range of 'width' bits.
  // A width of zero or one at least as wide as the accumulator leaves the value untouched.
  function automatic mac_acc_t sat_clamp(input mac_acc_t value, input int unsigned width);
    logic [MAC_ACC_W-1:0] one_v;
    mac_acc_t             max_v;
    mac_acc_t             min_v;
    mac_acc_t             res_v;
    one_v = {{(MAC_ACC_W-1){1'b0}}, 1'b1};
    max_v = value;
    min_v = value;
    res_v = value;
    if ((width == 32'd0) || (width >= MAC_ACC_W)) begin
      res_v = value;
    end else begin
      max_v = mac_acc_t'((one_v << (width - 32'd1)) - one_v);
      min_v = ~max_v;
      if (value > max_v) begin
        res_v = max_v;
      end else if (value < min_v) begin
        res_v = min_v;
      end else begin
        res_v = value;
      end
    end
    return res_v;
  endfunction

  // True when n is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned n);
    return (n != 32'd0) && ((n & (n - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/mac_result_fifo_if.sv
// Handshake bundle between the MAC, the result FIFO and its consumer.
// master: the side driving the MAC stream and the consumer ready.
// slave : the result FIFO itself.
interface mac_result_fifo_if
  import mac_pkg::*;
#(
  parameter int unsigned IN_W = MAC_ACC_W
) ();

  logic                   in_valid;
  logic signed [IN_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [IN_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/mac_fifo_core.sv
// Storage, pointers and occupancy for the result FIFO.
// A write into a full FIFO is accepted only when a read happens in the same
// cycle; otherwise it is ignored and the caller decides what to flag.
// Read data comes straight from the storage array (no output register).
module mac_fifo_core
  import mac_pkg::*;
#(
  parameter int unsigned DW    = MAC_ACC_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_push,
  input  logic                             i_pop,
  input  logic [DW-1:0]                    i_wdata,
  output logic [DW-1:0]                    o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]       o_count,
  output logic                             o_full,
  output logic                             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
    $error("mac_fifo_core: DEPTH must be a power of two and at least 2");
  end

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == {CNT_W{1'b0}});
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array: cleared on reset, written at the write pointer on an accepted push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= {DW{1'b0}};
      end
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Read/write pointers advance on accepted operations and wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: up on write only, down on read only, unchanged when both or neither happen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mac_result_fifo.sv
// Downstream stage of the MAC unit: keeps the last valid result of every
// VEC_LEN-long group, buffers it in a small FIFO and offers it on a
// valid/ready output. The MAC cannot be stalled, so a kept result arriving
// while the FIFO is full (and not being read) is dropped and 'overflow' sticks.
// Optional feature macro: MAC_SAT_EN -- clamp kept results to signed OUT_W
// bits before storage and raise sticky 'sat_flag' on each clamp. Without it,
// values are stored as-is and 'sat_flag' is tied low.
module mac_result_fifo
  import mac_pkg::*;
#(
  parameter int unsigned IN_W    = 20,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned VEC_LEN = 1,
  parameter int unsigned OUT_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  mac_result_fifo_if.slave              bus,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          overflow,
  output logic                          sat_flag
);

  localparam int unsigned GRP_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  if ((VEC_LEN < 1) || (OUT_W < 2) || (OUT_W > IN_W)) begin : g_bad_cfg
    $error("mac_result_fifo: need VEC_LEN>=1 and 2<=OUT_W<=IN_W");
  end

  logic [GRP_W-1:0]       r_grp;
  logic                   r_overflow;
  logic                   w_grp_last;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic signed [IN_W-1:0] w_store;
  logic [IN_W-1:0]        w_rdata;

  assign w_grp_last = (r_grp == GRP_W'(VEC_LEN - 1));
  assign w_push     = bus.in_valid && w_grp_last;
  assign w_pop      = !w_empty && bus.out_ready;

  // Group position: counts valid inputs and wraps after the last one of a group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grp <= {GRP_W{1'b0}};
    end else if (bus.in_valid) begin
      if (w_grp_last) begin
        r_grp <= {GRP_W{1'b0}};
      end else begin
        r_grp <= r_grp + GRP_W'(1);
      end
    end
  end

`ifdef MAC_SAT_EN
  mac_acc_t w_clamped;
  logic     w_clamp_hit;
  logic     r_sat_flag;

  // Clamp the incoming value to OUT_W signed bits and note whether it changed.
  always_comb begin
    w_clamped   = sat_clamp(mac_acc_t'(bus.in_data), OUT_W);
    w_store     = IN_W'(w_clamped);
    w_clamp_hit = (w_store != bus.in_data);
  end

  // Sticky record that a kept result had to be clamped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat_flag <= 1'b0;
    end else if (w_push && w_clamp_hit) begin
      r_sat_flag <= 1'b1;
    end
  end

  assign sat_flag = r_sat_flag;
`else
  assign w_store  = bus.in_data;
  assign sat_flag = 1'b0;
`endif

  // Sticky record that a kept result was lost to a full FIFO with no read that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;

  mac_fifo_core #(
    .DW    (IN_W),
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_store),
    .o_rdata (w_rdata),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_rdata;

endmodule

// File: tb/tb_mac_result_fifo.sv
// Self-checking bench for mac_result_fifo: a queue scoreboard holds the values
// the FIFO should contain; each stimulus cycle updates it and the DUT outputs
// are compared against it. A second instance with VEC_LEN=3 covers grouping.
module tb_mac_result_fifo;
  import mac_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_result_fifo_if #(.IN_W(20)) bus  ();
  mac_result_fifo_if #(.IN_W(20)) bus3 ();

  logic [2:0] count;
  logic [2:0] count3;
  logic       overflow;
  logic       overflow3;
  logic       sat_flag;
  logic       sat_flag3;

  mac_result_fifo #(.IN_W(20), .DEPTH(4), .VEC_LEN(1), .OUT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .count    (count),
    .overflow (overflow),
    .sat_flag (sat_flag)
  );

  mac_result_fifo #(.IN_W(20), .DEPTH(4), .VEC_LEN(3), .OUT_W(16)) dut3 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus3),
    .count    (count3),
    .overflow (overflow3),
    .sat_flag (sat_flag3)
  );

  int       n_checks = 0;
  int       n_pass   = 0;
  mac_acc_t q[$];
  mac_acc_t q3[$];
  logic     exp_ovf;
  logic     exp_sat;

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference saturation to 16-bit signed when the feature is built in.
  function automatic int sat_ref(input int v);
`ifdef MAC_SAT_EN
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
`else
    return v;
`endif
  endfunction

  // One clock of stimulus on the VEC_LEN=1 instance, with scoreboard update and checks.
  task automatic cycle(input logic v, input int d, input logic r);
    logic do_pop;
    bus.in_valid  = v;
    bus.in_data   = mac_acc_t'(d);
    bus.out_ready = r;
    do_pop = r && (q.size() != 0);
    if (do_pop) check_val("pop_data", bus.out_data, q[0]);
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (v) begin
      if (q.size() < DEPTH) q.push_back(mac_acc_t'(sat_ref(d)));
      else exp_ovf = 1'b1;
      if (sat_ref(d) != d) exp_sat = 1'b1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_val("count", count, q.size());
    check_val("out_valid", bus.out_valid, (q.size() != 0));
    check_val("overflow", overflow, exp_ovf);
    check_val("sat_flag", sat_flag, exp_sat);
    if (q.size() != 0) check_val("head", bus.out_data, q[0]);
  endtask

  initial begin
    reset          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus3.in_valid  = 1'b0;
    bus3.in_data   = '0;
    bus3.out_ready = 1'b0;
    exp_ovf        = 1'b0;
    exp_sat        = 1'b0;

    // Reset state
    #2;
    check_val("rst_count", count, 0);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_data", bus.out_data, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_sat_flag", sat_flag, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Single push, then pop
    cycle(1'b1, 1234, 1'b0);
    cycle(1'b0, 0, 1'b1);

    // Overfill, then drain in order
    for (int i = 1; i <= 5; i++) cycle(1'b1, i, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1);

    // Asynchronous reset mid-stream with three entries held
    for (int i = 7; i <= 9; i++) cycle(1'b1, i, 1'b0);
    check_val("pre_rst_count", count, 3);
    #3 reset = 1'b0;
    #1;
    check_val("async_count", count, 0);
    check_val("async_out_valid", bus.out_valid, 0);
    check_val("async_overflow", overflow, 0);
    check_val("async_out_data", bus.out_data, 0);
    q.delete();
    exp_ovf = 1'b0;
    exp_sat = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Full FIFO with simultaneous push and pop
    for (int i = 1; i <= 4; i++) cycle(1'b1, i, 1'b0);
    cycle(1'b1, 9, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1);

    // Saturation boundaries (pass-through when the feature is not built in)
    cycle(1'b1, 40000, 1'b0);
    cycle(1'b1, -40000, 1'b0);
    cycle(1'b1, 32767, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1);

    // Grouping: VEC_LEN=3 keeps every third valid input
    for (int i = 0; i < 6; i++) begin
      bus3.in_valid = 1'b1;
      bus3.in_data  = mac_acc_t'(10 + i);
      if ((i % 3) == 2) q3.push_back(mac_acc_t'(10 + i));
      @(posedge clk);
      #1;
    end
    bus3.in_valid = 1'b0;
    check_val("grp_count", count3, q3.size());
    check_val("grp_overflow", overflow3, 0);
    bus3.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check_val("grp_valid", bus3.out_valid, 1);
      check_val("grp_data", bus3.out_data, q3[0]);
      @(posedge clk);
      #1;
      void'(q3.pop_front());
    end
    bus3.out_ready = 1'b0;
    check_val("grp_empty_valid", bus3.out_valid, 0);
    check_val("grp_empty_count", count3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
